// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter. Sends start bit, DBIT data bits LSB
// first, an optional parity bit and SB_TICK ticks of stop, paced by the
// 16x oversampling enable s_tick. The serial line is registered.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | start bit (low) for 16 ticks
// DATA   | data bits, LSB first, 16 ticks each
// PARITY | parity bit for 16 ticks (PARITY_EN = 1 only)
// STOP   | line high for SB_TICK ticks, then done
module uart_tx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [4:0] S_LAST    = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  localparam logic       P_INIT    = (PARITY_ODD != 0);
  localparam logic       HAS_PAR   = (PARITY_EN != 0);

  state_t     state_reg, state_next;
  logic [4:0] s_reg, s_next;
  logic [2:0] n_reg, n_next;
  logic [7:0] b_reg, b_next;
  logic       p_reg, p_next;
  logic       tx_reg, tx_next;

  // State, counters, shift register and line register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= 5'd0;
      n_reg     <= 3'd0;
      b_reg     <= 8'd0;
      p_reg     <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      p_reg     <= p_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic; the line value is derived from the next state so that
  // tx changes on the same edge the FSM moves to the next bit.
  always_comb begin
    state_next   = state_reg;
    s_next       = s_reg;
    n_next       = n_reg;
    b_next       = b_reg;
    p_next       = p_reg;
    tx_done_tick = 1'b0;

    case (state_reg)
      IDLE: begin
        if (tx_start) begin
          b_next     = din;
          p_next     = P_INIT;
          s_next     = 5'd0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = 5'd0;
            n_next     = 3'd0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next = 5'd0;
            p_next = p_reg ^ b_reg[0];
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
              state_next = HAS_PAR ? PARITY : STOP;
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = 5'd0;
            state_next = STOP;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == STOP_LAST) begin
            tx_done_tick = 1'b1;
            state_next   = IDLE;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      PARITY:  tx_next = p_next;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. Four instances cover default
// framing, even parity, odd parity and DBIT=7 / SB_TICK=32. A bench-side
// receiver decodes the line by counting s_tick and sampling mid-bit; the
// expected bytes are queued when a frame is launched and popped on decode.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic [3:0] tx_w, busy_w, done_w;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [4];
  int tick_div = 0;

  logic [7:0] exp_q [$];

  uart_tx u0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .tx(tx_w[0]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .tx(tx_w[1]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]), .tx(tx_w[2]));

  uart_tx #(.DBIT(7), .SB_TICK(32)) u3 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]), .tx(tx_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s_tick once every 4 clk, driven on the falling edge
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_div = (tick_div == 3) ? 0 : tick_div + 1;
      s_tick = (tick_div == 0);
    end
  end

  // count tx_done_tick pulses after s_tick has settled for the cycle
  initial begin
    for (int i = 0; i < 4; i++) done_cnt[i] = 0;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 4; i++) if (done_w[i] === 1'b1) done_cnt[i]++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tx_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Launch a frame on all instances with a one-cycle tx_start and verify the
  // accept latency on instance d. Returns just after the accept edge + 1 clk.
  task automatic send(input int d, input logic [7:0] v);
    @(negedge clk);
    din = v;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx_w[d] !== 1'b0 || busy_w[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_latency dut%0d: tx=%b busy=%b, required tx=0 busy=1", d, tx_w[d], busy_w[d]);
    end
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Bench receiver: waits for the start bit, then counts ticks and samples
  // the line at tick 8 of each 16-tick bit until tx_busy drops.
  task automatic rx_frame(input int d, input int dbit, input int pe,
                          output logic [7:0] data, output logic par,
                          output int nticks, output bit frame_ok,
                          output int gap, output bit tmo);
    int cyc;
    int t;
    int j;
    data = 8'h00;
    par = 1'b0;
    nticks = 0;
    frame_ok = 1'b1;
    gap = 0;
    tmo = 1'b0;
    cyc = 0;
    while (tx_w[d] !== 1'b0) begin
      @(posedge clk);
      #1;
      cyc++;
      gap++;
      if (cyc > 4000) begin
        tmo = 1'b1;
        return;
      end
    end
    t = 0;
    while (busy_w[d] === 1'b1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 8000) begin
        tmo = 1'b1;
        return;
      end
      if (s_tick === 1'b1) begin
        t++;
        if (t % 16 == 8) begin
          j = t / 16;
          if (j == 0) begin
            if (tx_w[d] !== 1'b0) frame_ok = 1'b0;
          end else if (j <= dbit) begin
            data[j-1] = tx_w[d];
          end else if (pe != 0 && j == dbit + 1) begin
            par = tx_w[d];
          end
        end
        if (t > 16 * (1 + dbit + pe) && tx_w[d] !== 1'b1) frame_ok = 1'b0;
      end
    end
    nticks = t;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    tx_start = 1'b0;
    din = 8'h00;
    repeat (3) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (tx_w !== 4'hF || busy_w !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_state: tx=%b busy=%b, required tx=1111 busy=0000", tx_w, busy_w);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      #3;
      if (tx_w !== 4'hF || busy_w !== 4'h0 || done_w !== 4'h0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_quiet: %0d active cycles without tx_start, required 0", bad);
    end
  endtask

  task automatic test_basic();
    logic [7:0] data, e;
    logic par;
    int nt, gap, d0;
    bit ok, tmo;
    d0 = done_cnt[0];
    exp_q.push_back(8'hA5);
    send(0, 8'hA5);
    rx_frame(0, 8, 0, data, par, nt, ok, gap, tmo);
    e = exp_q.pop_front();
    n_checks++;
    if (tmo) begin
      n_fail++;
      $display("FAIL basic_timeout: no complete frame, required frame of %h", e);
    end
    n_checks++;
    if (data !== e || !ok) begin
      n_fail++;
      $display("FAIL basic_data: got %h framing_ok=%0d, required %h framing_ok=1", data, ok, e);
    end
    n_checks++;
    if (nt != 160) begin
      n_fail++;
      $display("FAIL basic_length: busy %0d ticks, required 160", nt);
    end
    n_checks++;
    if (done_cnt[0] - d0 != 1) begin
      n_fail++;
      $display("FAIL basic_done: %0d done pulses, required 1", done_cnt[0] - d0);
    end
    do_reset();
  endtask

  task automatic test_parity();
    int   dut_t [4] = '{1, 1, 2, 3};
    logic [7:0] din_t [4] = '{8'h07, 8'h03, 8'h03, 8'hFF};
    logic [7:0] data, e, mask;
    logic par, ep;
    int nt, gap, d, dbit, pe, sb;
    bit ok, tmo;
    for (int k = 0; k < 4; k++) begin
      d = dut_t[k];
      dbit = (d == 3) ? 7 : 8;
      pe = (d == 1 || d == 2) ? 1 : 0;
      sb = (d == 3) ? 32 : 16;
      mask = (d == 3) ? 8'h7F : 8'hFF;
      exp_q.push_back(din_t[k] & mask);
      ep = (^(din_t[k] & mask)) ^ (d == 2);
      send(d, din_t[k]);
      rx_frame(d, dbit, pe, data, par, nt, ok, gap, tmo);
      e = exp_q.pop_front();
      n_checks++;
      if (tmo || data !== e || !ok) begin
        n_fail++;
        $display("FAIL param_data dut%0d: got %h ok=%0d tmo=%0d, required %h", d, data, ok, tmo, e);
      end
      if (pe != 0) begin
        n_checks++;
        if (par !== ep) begin
          n_fail++;
          $display("FAIL parity_bit dut%0d din=%h: got %b, required %b", d, din_t[k], par, ep);
        end
      end
      n_checks++;
      if (nt != (1 + dbit + pe) * 16 + sb) begin
        n_fail++;
        $display("FAIL param_length dut%0d: %0d ticks, required %0d", d, nt, (1 + dbit + pe) * 16 + sb);
      end
      do_reset();
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] data, e;
    logic par;
    int nt, gap, d0, bad;
    bit ok, tmo;
    d0 = done_cnt[0];
    exp_q.push_back(8'h5A);
    send(0, 8'h5A);
    fork
      rx_frame(0, 8, 0, data, par, nt, ok, gap, tmo);
      begin
        repeat (300) @(negedge clk);
        din = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        din = 8'hFF;
      end
    join
    e = exp_q.pop_front();
    n_checks++;
    if (tmo || data !== e || !ok || nt != 160) begin
      n_fail++;
      $display("FAIL busy_ignore_data: got %h ticks=%0d tmo=%0d, required %h ticks=160", data, nt, tmo, e);
    end
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0 || done_cnt[0] - d0 != 1) begin
      n_fail++;
      $display("FAIL busy_no_second: %0d busy cycles, %0d done pulses, required 0 and 1", bad, done_cnt[0] - d0);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [7:0] data, e;
    logic par;
    int nt, gap;
    bit ok, tmo;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h3C);
    @(negedge clk);
    din = 8'h3C;
    tx_start = 1'b1;
    for (int f = 0; f < 2; f++) begin
      fork
        rx_frame(0, 8, 0, data, par, nt, ok, gap, tmo);
        begin
          if (f == 1) begin
            repeat (20) @(negedge clk);
            tx_start = 1'b0;
          end
        end
      join
      e = exp_q.pop_front();
      n_checks++;
      if (tmo || data !== e || !ok || nt != 160) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: got %h ticks=%0d tmo=%0d, required %h ticks=160", f, data, nt, tmo, e);
      end
      if (f == 1) begin
        n_checks++;
        if (gap != 1) begin
          n_fail++;
          $display("FAIL b2b_gap: %0d idle clk before second start, required 1", gap);
        end
      end
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (busy_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: busy=%b after release, required 0", busy_w[0]);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    int d0, bad;
    send(0, 8'h96);
    repeat (290) @(negedge clk);
    d0 = done_cnt[0];
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: tx=%b busy=%b, required tx=1 busy=0", tx_w[0], busy_w[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0 || done_cnt[0] != d0) begin
      n_fail++;
      $display("FAIL reset_mid_resume: %0d active cycles, %0d done pulses, required 0 and 0", bad, done_cnt[0] - d0);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] vals [3] = '{8'h00, 8'hFF, 8'h81};
    logic [7:0] data, e;
    logic par;
    int nt, gap, d0;
    bit ok, tmo;
    for (int k = 0; k < 3; k++) begin
      d0 = done_cnt[0];
      exp_q.push_back(vals[k]);
      send(0, vals[k]);
      rx_frame(0, 8, 0, data, par, nt, ok, gap, tmo);
      e = exp_q.pop_front();
      n_checks++;
      if (tmo || data !== e || !ok) begin
        n_fail++;
        $display("FAIL loopback_data: got %h ok=%0d tmo=%0d, required %h", data, ok, tmo, e);
      end
      n_checks++;
      if (done_cnt[0] - d0 != 1) begin
        n_fail++;
        $display("FAIL loopback_done: %0d done pulses, required 1", done_cnt[0] - d0);
      end
      repeat (5) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    tx_start = 1'b0;
    din = 8'h00;
    test_reset();
    test_basic();
    test_parity();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the UART datapath: it converts a parallel byte into an asynchronous serial frame on `tx`. The frame is start bit, DBIT data bits sent LSB first, an optional parity bit, then the stop bit(s). Bit timing comes from the shared 16x-oversampling `s_tick` enable produced by the baud-rate generator. The receive side of the same link consumes the frames, so the link can be looped back `tx`→`rx`.

## Interface
Parameters:
- DBIT, 8 — number of data bits, 5..8; only `din[DBIT-1:0]` is transmitted.
- SB_TICK, 16 — stop-bit length in ticks, 1..32 (16 = 1 stop, 24 = 1.5, 32 = 2).
- PARITY_EN, 0 — 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0 — 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- s_tick  in  1  one-cycle oversampling enable, 16 per bit period.
- tx_start  in  1  request to send `din`; sampled every cycle.
- din  in  8  byte to send; captured on the accept cycle.
- tx_busy  out  1  high from the accept cycle's next edge until the frame completes.
- tx_done_tick  out  1  one-cycle pulse when the frame completes.
- tx  out  1  serial line, registered, idle high.

## Operation
- **States:** idle, start, data, parity, stop.
- **Registers:**
  - 5-bit tick counter `s`.
  - 3-bit bit counter `n`.
  - 8-bit shift register `b`.
  - parity accumulator `p`.
  - registered `tx`.
- **idle:** `tx` = 1.
  - If `tx_start` = 1: capture `b` ← `din`, `p` ← PARITY_ODD, `s` ← 0, then go to start.
  - `tx_start` is a level request. Holding it high re-triggers on the first idle cycle after completion.
- **start:** `tx` = 0.
  - On each `s_tick`: if `s` = 15, then `s` ← 0, `n` ← 0, go to data. Otherwise `s` ← `s` + 1.
- **data:** `tx` = `b[0]`.
  - On each `s_tick` with `s` = 15: `s` ← 0, `p` ← `p` ^ `b[0]`, `b` ← `b` >> 1.
  - Then, if `n` = DBIT−1, go to parity (PARITY_EN = 1) or to stop. Otherwise `n` ← `n` + 1.
  - On an `s_tick` with `s` < 15: `s` ← `s` + 1.
- **parity:** `tx` = `p`.
  - After 16 ticks (`s` = 15 on an `s_tick`): `s` ← 0, go to stop.
- **stop:** `tx` = 1.
  - On an `s_tick` with `s` = SB_TICK−1: assert `tx_done_tick` for that cycle and go to idle.
  - Otherwise `s` ← `s` + 1.
- **Counter width:** `s` is 5 bits so that SB_TICK = 32 does not wrap before the compare.
- **`tx_start` outside idle:** ignored. This includes the `tx_done_tick` cycle; no queuing.
- **`din` timing:** changes to `din` after the accept cycle do not affect the frame in flight.
- **`tx_busy`:** equals (state ≠ idle).
- **Cycles without `s_tick`:** the FSM and counters hold; `tx` holds.

## Timing
- **Reset values:**
  - state = idle, `s` = 0, `n` = 0, `b` = 0, `p` = 0.
  - `tx` = 1, `tx_busy` = 0, `tx_done_tick` = 0.
- **Reset mid-frame:** on the next edge `tx` = 1 and state = idle; no partial frame resumes. The line never glitches low at reset.
- **Accept latency:** with `tx_start` high at edge k in idle, `tx` = 0 and `tx_busy` = 1 from edge k+1.
- **Bit durations:**
  - Start bit: exactly 16 `s_tick`s measured from the first tick after entry. The entry→first-tick interval adds up to one tick period of jitter on the start-bit length only.
  - Each data bit and the parity bit: 16 ticks.
  - Stop: SB_TICK ticks.
- **Frame length:** (1 + DBIT + PARITY_EN)·16 + SB_TICK ticks.
- **Completion:** `tx_done_tick` is asserted combinationally from state/counter/`s_tick` in the last stop tick cycle. Next edge: state = idle, `tx_busy` = 0.
- **Back-to-back frames:** minimum gap is one clk cycle of idle, then the next start bit.
- **`tx` registration:** `tx` is registered. All bit transitions occur one clk after the `s_tick` cycle that ends the previous bit.

## Test plan
- **Reset idle:** assert `reset` 3 cycles, `s_tick` every 4 clk → `tx` = 1, `tx_busy` = 0, `tx_done_tick` = 0 throughout; no activity without `tx_start`.
- **Basic frame:** default params, `din` = 8'hA5, one-cycle `tx_start` → line shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 16 ticks. Exactly one `tx_done_tick` at frame end; `tx_busy` high for 160 ticks.
- **Parity and stop length:**
  - PARITY_EN = 1, PARITY_ODD = 0, `din` = 8'h07 → parity bit 1.
  - PARITY_ODD = 1, `din` = 8'h03 → parity bit 1.
  - DBIT = 7, SB_TICK = 32, `din` = 8'hFF → 7 ones sent, stop lasts 32 ticks.
- **Start while busy:** pulse `tx_start` with `din` = 8'h00 mid-frame of 8'h5A; also change `din` mid-frame → frame carries 8'h5A unchanged, no second frame.
- **Back-to-back:** hold `tx_start` high with `din` = 8'h3C → second start bit begins 1 clk after the `tx_done_tick` cycle; line stays high only for the stop bit plus 1 clk.
- **Reset mid-frame and loopback:**
  - Assert `reset` during data bit 3 → `tx` = 1 next edge, `tx_busy` = 0, no `tx_done_tick`.
  - Then loop `tx` into the receiver for 8'h00, 8'hFF, 8'h81 → the receiver `dout` matches each byte with one `rx_done_tick` per frame.
